// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3).
// One result bit per clock; out-of-range digits are flagged and the result is masked to zero.
module bcd2bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t             state_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_d;
    logic [BCD_W-1:0]   shifted_d;
    logic [BIN_W-1:0]   bin_q;
    logic [BIN_W-1:0]   bin_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               bad_digit_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [BIN_W-1:0]   bin_out_q;

    // One iteration: shift the whole {bcd,bin} pair right, then pull every digit that landed at 8 or above back by 3.
    always_comb begin
        shifted_d = {1'b0, bcd_q[BCD_W-1:1]};
        bin_d     = {bcd_q[0], bin_q[BIN_W-1:1]};
        bcd_d     = shifted_d;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted_d[4*i +: 4] >= 4'd8) begin
                bcd_d[4*i +: 4] = shifted_d[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bad_digit_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bin_out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q      <= bcd_in;
                        bin_q      <= '0;
                        cnt_q      <= CNT_W'(BIN_W - 1);
                        err_q      <= bad_digit_d;
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        bin_out_q   <= err_q ? '0 : bin_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // Ready only returns via IDLE, so back-to-back words always see one idle cycle.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Scoreboard bench for bcd2bin_seq: a 3-digit and a 4-digit instance checked against a decimal reference model.
// Stimulus pushes expected results; independent monitors pop and compare when results appear.
module tb_bcd2bin_seq;
   localparam int BIN_W_A = 10;
   localparam int BIN_W_B = 14;

   typedef struct {
      int bin;
      int err;
      int acc;
   } exp_t;

   logic clock = 1'b0;
   logic reset;

   logic        inValid;
   logic        inReady;
   logic [11:0] bcdIn;
   logic        outValid;
   logic        outReady = 1'b1;
   logic [9:0]  binOut;
   logic        err;

   logic        inValidB;
   logic        inReadyB;
   logic [15:0] bcdInB;
   logic        outValidB;
   logic        outReadyB = 1'b1;
   logic [13:0] binOutB;
   logic        errB;

   int   cycle = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   readyMode = 0;
   exp_t sbq[$];
   exp_t sbqB[$];
   bit   prevValid = 1'b0;
   bit   releasePending = 1'b0;
   bit   prevValidB = 1'b0;
   exp_t expA;
   exp_t expB;

   bcd2bin_seq #(.DIGITS(3), .BIN_W(BIN_W_A)) dutA (
      .clk(clock), .rst(reset),
      .in_valid(inValid), .in_ready(inReady), .bcd_in(bcdIn),
      .out_valid(outValid), .out_ready(outReady), .bin_out(binOut), .err(err)
   );

   bcd2bin_seq #(.DIGITS(4), .BIN_W(BIN_W_B)) dutB (
      .clk(clock), .rst(reset),
      .in_valid(inValidB), .in_ready(inReadyB), .bcd_in(bcdInB),
      .out_valid(outValidB), .out_ready(outReadyB), .bin_out(binOutB), .err(errB)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   // Consumer readiness: always ready, random backpressure, or stalled.
   always @(posedge clock) begin
      #2;
      case (readyMode)
         0:       outReady = 1'b1;
         1:       outReady = 1'($urandom_range(0, 1));
         default: outReady = 1'b0;
      endcase
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual %0d required %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   task automatic failNow(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: expected event did not happen (cycle %0d)", name, cycle);
   endtask

   // Decimal meaning of the BCD word, computed digit by digit; any digit above 9 forces err and a zero result.
   function automatic exp_t refModel(input logic [15:0] w, input int nd, input int acc);
      exp_t e;
      e.bin = 0;
      e.err = 0;
      e.acc = acc;
      for (int i = nd - 1; i >= 0; i--) begin
         int d;
         d = int'((w >> (4 * i)) & 16'h000F);
         if (d > 9) e.err = 1;
         e.bin = e.bin * 10 + d;
      end
      if (e.err != 0) e.bin = 0;
      return e;
   endfunction

   function automatic logic [15:0] toBcd(input int n);
      logic [15:0] r;
      int v;
      r = '0;
      v = n;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Callers are positioned one time unit after a rising edge.
   task automatic applyStimulus(input logic [11:0] w);
      int waited;
      waited = 0;
      inValid = 1'b1;
      bcdIn = w;
      while (!inReady && waited < 300) begin
         @(posedge clock); #1;
         waited++;
      end
      if (!inReady) begin
         failNow("accept_timeout");
         inValid = 1'b0;
         return;
      end
      sbq.push_back(refModel({4'h0, w}, 3, cycle + 1));
      @(posedge clock); #1;
      inValid = 1'b0;
   endtask

   task automatic applyStimulusB(input logic [15:0] w);
      int waited;
      waited = 0;
      inValidB = 1'b1;
      bcdInB = w;
      while (!inReadyB && waited < 300) begin
         @(posedge clock); #1;
         waited++;
      end
      if (!inReadyB) begin
         failNow("b_accept_timeout");
         inValidB = 1'b0;
         return;
      end
      sbqB.push_back(refModel(w, 4, cycle + 1));
      @(posedge clock); #1;
      inValidB = 1'b0;
   endtask

   task automatic waitDrain();
      int waited;
      waited = 0;
      while ((sbq.size() != 0 || sbqB.size() != 0) && waited < 1000) begin
         @(posedge clock); #1;
         waited++;
      end
      if (sbq.size() != 0 || sbqB.size() != 0) begin
         failNow("drain_timeout");
         sbq.delete();
         sbqB.delete();
      end
      @(posedge clock); #1;
   endtask

   // Monitor for the 3-digit instance: latency on the first valid cycle, value every valid cycle, pop on handshake.
   always @(negedge clock) begin
      if (reset) begin
         prevValid = 1'b0;
         releasePending = 1'b0;
      end else begin
         if (releasePending) begin
            checkOutput("in_ready_after_handshake", int'(inReady), 1);
            checkOutput("out_valid_after_handshake", int'(outValid), 0);
            releasePending = 1'b0;
         end
         if (outValid) begin
            if (sbq.size() == 0) begin
               if (!prevValid) failNow("unexpected_out_valid");
            end else begin
               expA = sbq[0];
               if (!prevValid) checkOutput("latency", cycle - expA.acc, BIN_W_A);
               checkOutput("bin_out", int'(binOut), expA.bin);
               checkOutput("err", int'(err), expA.err);
               checkOutput("in_ready_in_done", int'(inReady), 0);
               if (outReady) begin
                  void'(sbq.pop_front());
                  releasePending = 1'b1;
               end
            end
         end
         prevValid = outValid;
      end
   end

   // Monitor for the 4-digit instance; its consumer is always ready.
   always @(negedge clock) begin
      if (reset) begin
         prevValidB = 1'b0;
      end else begin
         if (outValidB && !prevValidB) begin
            if (sbqB.size() == 0) begin
               failNow("b_unexpected_out_valid");
            end else begin
               expB = sbqB.pop_front();
               checkOutput("b_latency", cycle - expB.acc, BIN_W_B);
               checkOutput("b_bin_out", int'(binOutB), expB.bin);
               checkOutput("b_err", int'(errB), expB.err);
            end
         end
         prevValidB = outValidB;
      end
   end

   initial begin
      logic [11:0] directed [8];
      logic [15:0] t;
      int waited;

      reset = 1'b1;
      inValid = 1'b0;
      bcdIn = '0;
      inValidB = 1'b0;
      bcdInB = '0;
      readyMode = 0;
      #3;
      checkOutput("reset_in_ready", int'(inReady), 1);
      checkOutput("reset_out_valid", int'(outValid), 0);
      checkOutput("reset_bin_out", int'(binOut), 0);
      checkOutput("reset_err", int'(err), 0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;

      directed = '{12'h999, 12'h000, 12'h001, 12'h010, 12'h100, 12'h512, 12'h1A5, 12'h105};
      foreach (directed[i]) applyStimulus(directed[i]);
      waitDrain();

      // Stalled consumer: result must hold, and words offered during CONV/DONE must be ignored.
      readyMode = 2;
      @(posedge clock); #1;
      applyStimulus(12'h250);
      inValid = 1'b1;
      bcdIn = 12'h777;
      checkOutput("in_ready_in_conv", int'(inReady), 0);
      @(posedge clock); #1;
      inValid = 1'b0;
      waited = 0;
      while (!outValid && waited < 50) begin
         @(posedge clock); #1;
         waited++;
      end
      if (!outValid) failNow("backpressure_out_valid");
      for (int i = 0; i < 5; i++) begin
         inValid = i[0];
         bcdIn = 12'h777;
         checkOutput("out_valid_held", int'(outValid), 1);
         checkOutput("bin_out_held", int'(binOut), 250);
         @(posedge clock); #1;
      end
      inValid = 1'b0;
      readyMode = 0;
      waitDrain();

      // Reset in the middle of a conversion discards the word.
      applyStimulus(12'h999);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      sbq.delete();
      checkOutput("midreset_in_ready", int'(inReady), 1);
      checkOutput("midreset_out_valid", int'(outValid), 0);
      checkOutput("midreset_bin_out", int'(binOut), 0);
      checkOutput("midreset_err", int'(err), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      applyStimulus(12'h042);
      waitDrain();

      for (int n = 0; n < 1000; n++) begin
         t = toBcd(n);
         applyStimulus(t[11:0]);
      end
      waitDrain();

      readyMode = 1;
      for (int n = 0; n < 150; n++) begin
         applyStimulus(12'($urandom_range(0, 4095)));
         repeat ($urandom_range(0, 3)) @(posedge clock);
         #1;
      end
      readyMode = 0;
      waitDrain();

      applyStimulusB(16'h9999);
      applyStimulusB(16'h0000);
      applyStimulusB(16'h1A00);
      for (int n = 0; n < 20; n++) applyStimulusB(toBcd($urandom_range(0, 9999)));
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
